alu_op_sequencer: RTL

Sequencing controller for the 8-bit ALU datapath. Accepts one operation request at a time (opcode plus two operands) over a valid/ready handshake and executes it. ADD, AND and XOR complete in a single execute cycle; MUL runs as an iterative shift-add over WIDTH cycles. The controller drives the result-mux select and returns a 16-bit result over a second valid/ready handshake. It sits between the instruction/host side and the four-way result mux, and is the only writer of that mux's select.

---
 rtl/alu_op_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer for the 8-bit ALU datapath with iterative multiply
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           opcode,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           mux_sel,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_COPY = CW'(WIDTH);

    logic [1:0]           state_q,   state_d;
    logic [1:0]           mux_sel_q, mux_sel_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;
    logic [WIDTH:0]       sum;

    assign sum = {1'b0, mcand_q[WIDTH-1:0]} + {1'b0, mplier_q};

    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mux_sel_d = opcode;
                    mcand_d   = {{WIDTH{1'b0}}, operand_a};
                    mplier_d  = operand_b;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opcode == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                case (mux_sel_q)
                    OP_ADD:  result_d = {{(WIDTH-1){1'b0}}, sum};
                    OP_AND:  result_d = {{WIDTH{1'b0}}, mcand_q[WIDTH-1:0] & mplier_q};
                    default: result_d = {{WIDTH{1'b0}}, mcand_q[WIDTH-1:0] ^ mplier_q};
                endcase
                state_d = S_DONE;
            end
            S_MUL: begin
                // WIDTH shift-add iterations, then one cycle to publish the accumulator
                if (cnt_q == CNT_COPY) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mux_sel_q <= 2'b00;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign mux_sel   = mux_sel_q;

endmodule
